data_mem_mmio: RTL

Data-side memory subsystem sitting directly downstream of the `cpu` data port. It consumes `daddr`, `dwdata` and `dwe` from the MEM stage and returns `drdata` in the same cycle. It provides word-organised RAM with byte-lane writes. It also provides a small memory-mapped I/O window: a free-running cycle counter, a buffered debug console with a valid/ready drain handshake, and a drop counter.

---
 rtl/data_mem_mmio.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/data_mem_mmio.sv
`timescale 1ns/1ps
// data_mem_mmio: data-side memory for the cpu MEM stage.
// daddr[31]=0 selects a word RAM with byte-lane writes and a combinational read.
// daddr[31]=1 selects a small MMIO window with four registers:
// a cycle counter, a console FIFO push/status port, a drop counter and a zero register.
module data_mem_mmio #(
  parameter int MEM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwe,
  output logic [31:0] drdata,
  output logic [7:0]  con_data,
  output logic        con_valid,
  input  logic        con_ready
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // Address decode
  logic          mmio_sel;
  logic [1:0]    reg_sel;
  logic [AW-1:0] ram_idx;
  logic [3:0]    ram_we;
  logic          wr_any;
  logic          cyc_clr;
  logic          drops_clr;
  logic          push_req;

  assign mmio_sel  = daddr[31];
  assign reg_sel   = daddr[3:2];
  assign ram_idx   = daddr[AW+1:2];
  assign wr_any    = |dwe;
  assign ram_we    = mmio_sel ? 4'b0000 : dwe;
  assign cyc_clr   = mmio_sel && (reg_sel == 2'd0) && wr_any;
  assign push_req  = mmio_sel && (reg_sel == 2'd1) && dwe[0];
  assign drops_clr = mmio_sel && (reg_sel == 2'd2) && wr_any;

  // Address bits that neither region decodes; RAM aliases across them.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{daddr[30:AW+2], daddr[1:0]};

  // Storage (no reset: RAM and FIFO contents survive reset)
  logic [31:0] ram_q  [MEM_WORDS];
  logic [7:0]  fifo_q [FIFO_DEPTH];

  // Control state
  logic [31:0]   cycle_q, cycle_d;
  logic [31:0]   drops_q, drops_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;

  logic pop;
  logic push_ok;
  logic push_drop;
  logic fifo_full;
  logic fifo_empty;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign con_valid  = !fifo_empty;
  assign pop        = con_valid && con_ready;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign push_ok    = push_req && (!fifo_full || pop);
  assign push_drop  = push_req && !push_ok;
  assign con_data   = con_valid ? fifo_q[rd_ptr_q] : 8'h00;

  // RAM byte-lane write; lanes without an enable keep their old byte
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_we[b]) begin
        ram_q[ram_idx][8*b +: 8] <= dwdata[8*b +: 8];
      end
    end
  end

  // Console FIFO entry write at the tail pointer
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_q[wr_ptr_q] <= dwdata[7:0];
    end
  end

  // Next-state for the counters and FIFO bookkeeping
  always_comb begin
    cycle_d  = cyc_clr ? 32'd0 : cycle_q + 32'd1;
    drops_d  = drops_q;
    if (drops_clr) begin
      drops_d = 32'd0;
    end else if (push_drop) begin
      drops_d = drops_q + 32'd1;
    end
    rd_ptr_d = pop     ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset clears everything except the storage arrays
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q  <= 32'd0;
      drops_q  <= 32'd0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      cycle_q  <= cycle_d;
      drops_q  <= drops_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Combinational read mux; reflects state before the current edge
  logic [7:0]  count8;
  logic [31:0] status;
  assign count8 = 8'(count_q);
  assign status = {22'b0, fifo_empty, fifo_full, count8};

  always_comb begin
    drdata = 32'd0;
    if (!mmio_sel) begin
      drdata = ram_q[ram_idx];
    end else begin
      case (reg_sel)
        2'd0:    drdata = cycle_q;
        2'd1:    drdata = status;
        2'd2:    drdata = drops_q;
        default: drdata = 32'd0;
      endcase
    end
  end

endmodule
